// File: rtl/fp_sqrt_resbuf.sv
// Result buffer behind the FP square-root unit: credit-tracked circular FIFO
// holding {result, tag, status} until the consumer accepts it.
module fp_sqrt_resbuf #(
   parameter int FP_WIDTH   = 32,
   parameter int TAG_WIDTH  = 4,
   parameter int STAT_WIDTH = 8,
   parameter int DEPTH      = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        Issue_i,
   output logic                        Ready_o,
   input  logic                        Valid_i,
   input  logic [FP_WIDTH-1:0]         Res_i,
   input  logic [TAG_WIDTH-1:0]        Tag_i,
   input  logic [STAT_WIDTH-1:0]       Status_i,
   output logic                        Valid_o,
   input  logic                        Ready_i,
   output logic [FP_WIDTH-1:0]         Res_o,
   output logic [TAG_WIDTH-1:0]        Tag_o,
   output logic [STAT_WIDTH-1:0]       Status_o,
   input  logic                        Flush_i,
   output logic [$clog2(DEPTH):0]      Count_o,
   output logic                        Overflow_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL   = CW'(DEPTH);
   localparam logic [CW-1:0] IF_MAX = '1;

   typedef struct packed {
      logic [FP_WIDTH-1:0]   res;
      logic [TAG_WIDTH-1:0]  tag;
      logic [STAT_WIDTH-1:0] status;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          head;
   logic [PW-1:0]   wr_q, rd_q;
   logic [CW-1:0]   count_q, inflight_q, inflight_d;
   logic            ovf_q, ovf_set;
   logic            full, push, pop;

   always_comb begin
      full    = (count_q == FULL);
      Valid_o = (count_q != '0);
      pop     = Valid_o & Ready_i & ~Flush_i;
      push    = Valid_i & ~Flush_i & (~full | pop);
      // Credit check uses registered state only, so Ready_o has no input-to-output path.
      Ready_o = ({1'b0, count_q} + {1'b0, inflight_q}) < (CW+1)'(DEPTH);
      ovf_set = (Valid_i & full & ~pop & ~Flush_i)
              | (Issue_i & ~Ready_o)
              | (Valid_i & (inflight_q == '0));
   end

   always_comb begin
      inflight_d = inflight_q;
      unique case ({Issue_i, Valid_i})
         2'b10:   if (inflight_q != IF_MAX) inflight_d = inflight_q + 1'b1;
         2'b01:   if (inflight_q != '0)     inflight_d = inflight_q - 1'b1;
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q       <= '0;
         rd_q       <= '0;
         count_q    <= '0;
         inflight_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
         if (ovf_set) ovf_q <= 1'b1;
         if (Flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
         end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
         end
      end
   end

   // Storage needs no reset: outputs are masked whenever the buffer is empty.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_q] <= '{res: Res_i, tag: Tag_i, status: Status_i};
   end

   always_comb begin
      head     = mem_q[rd_q];
      Res_o    = Valid_o ? head.res    : '0;
      Tag_o    = Valid_o ? head.tag    : '0;
      Status_o = Valid_o ? head.status : '0;
   end

   assign Count_o    = count_q;
   assign Overflow_o = ovf_q;

endmodule

// File: tb/tb_fp_sqrt_resbuf.sv
// Directed bench for fp_sqrt_resbuf: inputs driven and outputs sampled on the
// falling edge, expected values hand-derived from the buffer/credit rules.
module tb_fp_sqrt_resbuf;
   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        Issue_i = 1'b0, Ready_o;
   logic        Valid_i = 1'b0;
   logic [31:0] Res_i = '0;
   logic [3:0]  Tag_i = '0;
   logic [7:0]  Status_i = '0;
   logic        Valid_o, Ready_i = 1'b0;
   logic [31:0] Res_o;
   logic [3:0]  Tag_o;
   logic [7:0]  Status_o;
   logic        Flush_i = 1'b0;
   logic [2:0]  Count_o;
   logic        Overflow_o;

   int n_cmp = 0;
   int n_err = 0;

   fp_sqrt_resbuf dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .Issue_i(Issue_i), .Ready_o(Ready_o),
      .Valid_i(Valid_i), .Res_i(Res_i), .Tag_i(Tag_i), .Status_i(Status_i),
      .Valid_o(Valid_o), .Ready_i(Ready_i), .Res_o(Res_o), .Tag_o(Tag_o),
      .Status_o(Status_o), .Flush_i(Flush_i), .Count_o(Count_o),
      .Overflow_o(Overflow_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic res_in(input logic v, input logic [3:0] t, input logic [31:0] r);
      Valid_i  = v;
      Tag_i    = t;
      Res_i    = r;
      Status_i = {4'h5, t};
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      Issue_i = 1'b0; Ready_i = 1'b0; Flush_i = 1'b0;
      res_in(1'b0, 4'd0, 32'd0);
      cyc();
      rst_ni = 1'b1;
      cyc();
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".valid"}, 32'(Valid_o), 32'd0);
      chk({tag, ".count"}, 32'(Count_o), 32'd0);
      chk({tag, ".res"},   Res_o, 32'd0);
      chk({tag, ".tag"},   32'(Tag_o), 32'd0);
      chk({tag, ".stat"},  32'(Status_o), 32'd0);
      chk({tag, ".ready"}, 32'(Ready_o), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] exp_tags [4];

      // reset values
      @(negedge clk_i);
      chk_idle("rst");
      chk("rst.ovf", 32'(Overflow_o), 32'd0);
      do_reset();

      // single op round trip
      Issue_i = 1'b1; cyc();
      Issue_i = 1'b0; cyc();
      cyc();
      res_in(1'b1, 4'd3, 32'h4000_0000); Ready_i = 1'b1;
      chk("single.nobypass", 32'(Valid_o), 32'd0);
      cyc();
      res_in(1'b0, 4'd0, 32'd0);
      chk("single.valid", 32'(Valid_o), 32'd1);
      chk("single.res",   Res_o, 32'h4000_0000);
      chk("single.tag",   32'(Tag_o), 32'd3);
      chk("single.stat",  32'(Status_o), 32'h53);
      chk("single.count", 32'(Count_o), 32'd1);
      cyc();
      chk_idle("single.after");
      chk("single.ovf", 32'(Overflow_o), 32'd0);
      Ready_i = 1'b0;

      // credit limit, then fill with backpressure, drain across the wrap
      do_reset();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("credit.ready%0d", i), 32'(Ready_o), 32'd1);
         Issue_i = 1'b1; cyc();
      end
      Issue_i = 1'b0;
      chk("credit.full", 32'(Ready_o), 32'd0);
      for (int i = 0; i < 4; i++) begin
         res_in(1'b1, 4'(i), 32'h3F80_0000 + 32'(i)); cyc();
      end
      res_in(1'b0, 4'd0, 32'd0);
      chk("fill.count", 32'(Count_o), 32'd4);
      chk("fill.tag",   32'(Tag_o), 32'd0);
      chk("fill.ready", 32'(Ready_o), 32'd0);
      cyc(); cyc();
      chk("fill.stable.tag", 32'(Tag_o), 32'd0);
      chk("fill.stable.res", Res_o, 32'h3F80_0000);
      Ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("drain.tag%0d", i), 32'(Tag_o), 32'(i));
         cyc();
         if (i == 0) chk("credit.back", 32'(Ready_o), 32'd1);
      end
      chk_idle("drain.end");
      chk("drain.ovf", 32'(Overflow_o), 32'd0);
      Ready_i = 1'b0;

      // full with simultaneous push/pop, pointers offset by one entry first
      do_reset();
      Issue_i = 1'b1; cyc();
      Issue_i = 1'b0; res_in(1'b1, 4'd9, 32'd9); cyc();
      res_in(1'b0, 4'd0, 32'd0); Ready_i = 1'b1;
      chk("fp.pre.tag", 32'(Tag_o), 32'd9);
      cyc();
      Ready_i = 1'b0;
      Issue_i = 1'b1;
      for (int i = 0; i < 4; i++) cyc();
      chk("fp.pre.ovf", 32'(Overflow_o), 32'd0);
      // A fifth in-flight op can only exist by over-issuing, which is itself flagged.
      cyc();
      Issue_i = 1'b0;
      chk("fp.overissue.ovf", 32'(Overflow_o), 32'd1);
      for (int i = 0; i < 4; i++) begin
         res_in(1'b1, 4'(i), 32'(i)); cyc();
      end
      chk("fp.count", 32'(Count_o), 32'd4);
      res_in(1'b1, 4'd5, 32'd5); Ready_i = 1'b1;
      cyc();
      res_in(1'b0, 4'd0, 32'd0);
      chk("fp.count.hold", 32'(Count_o), 32'd4);
      exp_tags = '{4'd1, 4'd2, 4'd3, 4'd5};
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("fp.tag%0d", i), 32'(Tag_o), 32'(exp_tags[i]));
         cyc();
      end
      chk("fp.empty", 32'(Count_o), 32'd0);
      Ready_i = 1'b0;

      // overflow drop at full, flag sticky until reset
      do_reset();
      Issue_i = 1'b1;
      for (int i = 0; i < 4; i++) cyc();
      Issue_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         res_in(1'b1, 4'(i), 32'(i)); cyc();
      end
      chk("ovf.pre", 32'(Overflow_o), 32'd0);
      res_in(1'b1, 4'd7, 32'd7); cyc();
      res_in(1'b0, 4'd0, 32'd0);
      chk("ovf.count", 32'(Count_o), 32'd4);
      chk("ovf.flag",  32'(Overflow_o), 32'd1);
      chk("ovf.head",  32'(Tag_o), 32'd0);
      Ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("ovf.tag%0d", i), 32'(Tag_o), 32'(i));
         cyc();
      end
      Ready_i = 1'b0;
      chk("ovf.dropped", 32'(Valid_o), 32'd0);
      Flush_i = 1'b1; cyc(); Flush_i = 1'b0;
      chk("ovf.sticky", 32'(Overflow_o), 32'd1);
      do_reset();
      chk("ovf.cleared", 32'(Overflow_o), 32'd0);

      // flush keeps the outstanding credit
      Issue_i = 1'b1;
      for (int i = 0; i < 4; i++) cyc();
      Issue_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         res_in(1'b1, 4'(i), 32'(i)); cyc();
      end
      res_in(1'b0, 4'd0, 32'd0);
      chk("flush.pre.count", 32'(Count_o), 32'd3);
      chk("flush.pre.ready", 32'(Ready_o), 32'd0);
      Flush_i = 1'b1; cyc(); Flush_i = 1'b0;
      chk_idle("flush");
      res_in(1'b1, 4'd6, 32'd6); cyc();
      res_in(1'b0, 4'd0, 32'd0);
      chk("flush.late.tag", 32'(Tag_o), 32'd6);
      chk("flush.late.ovf", 32'(Overflow_o), 32'd0);

      // asynchronous reset mid-stream
      Issue_i = 1'b1; cyc();
      #1 rst_ni = 1'b0;
      #1;
      Issue_i = 1'b0;
      chk_idle("async");
      chk("async.ovf", 32'(Overflow_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      cyc();
      chk_idle("post");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
